// File: rtl/tsmac_rx_frame_parser.sv
// TSMAC RX frame parser: strips preamble/SFD, checks FCS/length/rx_er,
// streams payload without FCS and keeps saturating frame counters.
module tsmac_rx_frame_parser #(
  parameter int MIN_LEN   = 64,
  parameter int MAX_LEN   = 1518,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst,
  input  logic                 rd_vld,
  input  logic [9:0]           rd_data,
  output logic                 rd_en,
  output logic                 out_vld,
  output logic [7:0]           out_data,
  output logic                 out_last,
  output logic                 out_err,
  output logic [10:0]          out_len,
  output logic [CNT_WIDTH-1:0] frm_ok_cnt,
  output logic [CNT_WIDTH-1:0] frm_err_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  localparam logic [10:0] MIN_L   = 11'(MIN_LEN);
  localparam logic [10:0] MAX_L   = 11'(MAX_LEN);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  function automatic logic [31:0] crc_step(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++)
      r = (r[0] ^ d[i]) ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  state_t          state;
  logic [31:0]     crc;
  logic [10:0]     len;
  logic [2:0]      held;
  logic [4:0][7:0] dl;
  logic            err_seen;

  logic       acc, dv, er, full, start, frm_bad;
  logic       bump_ok, bump_err;
  logic [7:0] rxd;

  always_comb begin
    acc   = rd_en & rd_vld;
    rxd   = rd_data[7:0];
    dv    = rd_data[8];
    er    = rd_data[9];
    full  = (held == 3'd5);
    start = acc & dv & (rxd == 8'hD5)
          & ((state == IDLE) | (state == PRE));
    frm_bad = (crc != RESIDUE) | err_seen | er
            | (len < MIN_L) | (len > MAX_L);
    bump_ok  = 1'b0;
    bump_err = 1'b0;
    if (acc & ~dv) begin
      // a DATA end counts good only if a last byte goes out clean
      bump_ok  = (state == DATA) & full & ~frm_bad;
      bump_err = (state == PRE) | (state == DROP)
               | ((state == DATA) & ~(full & ~frm_bad));
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state    <= IDLE;
      rd_en    <= 1'b0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_err  <= 1'b0;
      out_data <= '0;
      out_len  <= '0;
      crc      <= '1;
      len      <= '0;
      held     <= '0;
      dl       <= '0;
      err_seen <= 1'b0;
    end else begin
      rd_en    <= 1'b1;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      if (start) begin
        crc      <= '1;
        len      <= '0;
        held     <= '0;
        err_seen <= 1'b0;
      end
      if (acc) begin
        unique case (state)
          IDLE: begin
            if (dv) begin
              if (rxd == 8'h55)      state <= PRE;
              else if (rxd == 8'hD5) state <= DATA;
              else                   state <= DROP;
            end
          end
          PRE: begin
            if (!dv)                 state <= IDLE;
            else if (rxd == 8'hD5)   state <= DATA;
            else if (rxd != 8'h55)   state <= DROP;
          end
          DATA: begin
            if (dv) begin
              crc      <= crc_step(crc, rxd);
              len      <= (len == 11'h7FF) ? len : len + 11'd1;
              err_seen <= err_seen | er;
              dl       <= {dl[3:0], rxd};
              if (full) begin
                out_vld  <= 1'b1;
                out_data <= dl[4];
              end else begin
                held <= held + 3'd1;
              end
            end else begin
              state <= IDLE;
              // oldest held byte is N-5; the four younger are FCS
              if (full) begin
                out_vld  <= 1'b1;
                out_last <= 1'b1;
                out_data <= dl[4];
                out_len  <= len;
                out_err  <= frm_bad;
              end
            end
          end
          DROP: begin
            if (!dv) state <= IDLE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      frm_ok_cnt  <= '0;
      frm_err_cnt <= '0;
    end else begin
      if (bump_ok && frm_ok_cnt != CNT_MAX)
        frm_ok_cnt <= frm_ok_cnt + 1'b1;
      if (bump_err && frm_err_cnt != CNT_MAX)
        frm_err_cnt <= frm_err_cnt + 1'b1;
    end
  end

endmodule
